// File: rtl/dm_pkg.sv
// Shared definitions for the DM frame RAM reader: RAM geometry and reader FSM states.
package dm_pkg;

    localparam int DM_RAM_AW    = 5;
    localparam int DM_RAM_DW    = 16;
    localparam int DM_RAM_DEPTH = 1 << DM_RAM_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dm_skid_buf.sv
// Two-entry FIFO of {last, data}. The head register keeps its last value when
// the buffer empties, so the stream data holds steady between words.
module dm_skid_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic [W-1:0] data_out,
    output logic         valid,
    output logic [1:0]   occupancy
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   occ_q;
    logic         pop_ok;

    assign pop_ok = pop && (occ_q != 2'd0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= data_in;
                    else               tail_q <= data_in;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) head_q <= tail_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged, entries advance.
                    if (occ_q == 2'd1) begin
                        head_q <= data_in;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out  = head_q;
    assign valid     = (occ_q != 2'd0);
    assign occupancy = occ_q;

endmodule

// File: rtl/dm_frame_reader.sv
// Read-side sequencer for the DM frame RAM: walks COUNT addresses from START_ADDR,
// absorbs the one-cycle RAM latency and streams words out on a valid/ready port.
module dm_frame_reader
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_RAM_AW,
    parameter int DATA_WIDTH = DM_RAM_DW
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state,
    output logic [1:0]            dbg_occupancy
);

    // Stream handshake: a word transfers on a rising edge where out_valid && out_ready.
    // out_valid never drops and out_data/out_last never change until that transfer.

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(1 << ADDR_WIDTH);

    dm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         remain_q;
    logic                  in_flight_q;
    logic                  last_flight_q;
    logic                  done_q;
    logic [CW-1:0]         count_sat;
    logic [2:0]            pending;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  buf_valid;
    logic [1:0]            buf_occ;
    logic [DATA_WIDTH:0]   buf_out;

    assign count_sat  = (count > MAX_COUNT) ? MAX_COUNT : count;
    assign pop        = buf_valid && out_ready;
    // A read may only be issued if its returning word is guaranteed a buffer slot.
    assign pending    = {1'b0, buf_occ} + {2'b00, in_flight_q};
    assign issue      = (state_q == ST_ISSUE) && (pending < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (remain_q == CW'(1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && (count_sat != '0)) state_d = ST_ISSUE;
            ST_ISSUE: if (last_issue)                 state_d = ST_DRAIN;
            ST_DRAIN: if (pop && out_last)            state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q        <= '0;
            remain_q      <= '0;
            in_flight_q   <= 1'b0;
            last_flight_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            in_flight_q   <= issue;
            last_flight_q <= last_issue;
            done_q        <= ((state_q == ST_IDLE) && start && (count_sat == '0)) ||
                             ((state_q == ST_DRAIN) && pop && out_last);
            if ((state_q == ST_IDLE) && start) begin
                addr_q   <= start_addr;
                remain_q <= count_sat;
            end else if (issue) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end
        end
    end

    dm_skid_buf #(.W(DATA_WIDTH + 1)) u_buf (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (in_flight_q),
        .data_in   ({last_flight_q, rd}),
        .pop       (pop),
        .data_out  (buf_out),
        .valid     (buf_valid),
        .occupancy (buf_occ)
    );

    assign raddr         = addr_q;
    assign ren           = issue;
    assign out_data      = buf_out[DATA_WIDTH-1:0];
    assign out_valid     = buf_valid;
    assign out_last      = buf_valid && buf_out[DATA_WIDTH];
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign dbg_state     = state_q;
    assign dbg_occupancy = buf_occ;

endmodule

// File: tb/tb_dm_frame_reader.sv
// Scoreboard bench for dm_frame_reader with a behavioural 32x16 synchronous-read RAM.
module tb_dm_frame_reader;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  count;
  logic [4:0]  raddr;
  logic        ren;
  logic [15:0] rd;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_occupancy;

  logic [15:0] mem [32];
  logic [16:0] exp_q[$];
  logic [4:0]  exp_addr_q[$];
  int          checks;
  int          failures;
  int          words_seen;
  bit          rand_ready;
  bit          prev_hold;
  logic [15:0] prev_data;
  logic        prev_last;

  dm_frame_reader dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .start         (start),
    .start_addr    (start_addr),
    .count         (count),
    .raddr         (raddr),
    .ren           (ren),
    .rd            (rd),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state),
    .dbg_occupancy (dbg_occupancy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: data appears the cycle after ren
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    rd = 16'h0;
  end
  always @(posedge clk) if (ren) rd <= mem[raddr];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: read addresses, stream words, stability under backpressure
  always @(negedge clk) begin
    if (!arst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (ren) begin
        if (exp_addr_q.size() == 0) check("unexpected_ren", 32'(raddr), 32'hFFFF);
        else check("raddr", 32'(raddr), 32'(exp_addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_q.size() == 0) check("unexpected_word", 32'({out_last, out_data}), 32'h1FFFF);
        else check("word", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      end
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_last, out_data}), 32'({prev_last, prev_data}));
      end
      if (out_valid && !out_ready) check("occupancy_le_2", 32'(dbg_occupancy <= 2'd2), 32'd1);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  // driver: random 50% ready when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_frame(input logic [4:0] a, input logic [5:0] c);
    int n;
    logic [4:0] ad;
    n = (c > 6'd32) ? 32 : int'(c);
    for (int i = 0; i < n; i++) begin
      ad = a + 5'(i);
      exp_addr_q.push_back(ad);
      exp_q.push_back({(i == n - 1), 16'hA000 + 16'(ad)});
    end
  endtask

  task automatic run_frame(input logic [4:0] a, input logic [5:0] c, input bit inj, input int exp_done);
    int got;
    got = -1;
    push_frame(a, c);
    start = 1'b1; start_addr = a; count = c;
    step();
    start = 1'b0; start_addr = 5'($urandom); count = 6'($urandom);
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        got = k + 1;
        break;
      end
      start = inj && (k == 3);
      step();
    end
    start = 1'b0;
    if (got < 0) check("done_timeout", 32'd0, 32'd1);
    if (exp_done > 0) check("done_cycle", 32'(got), 32'(exp_done));
    check("busy_at_done", 32'(busy), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    step();
    check("done_pulse_ends", 32'(done), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; words_seen = 0;
    rand_ready = 1'b0; prev_hold = 1'b0;
    arst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
    step(); step();
    check("rst_ren", 32'(ren), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    arst_n = 1'b1;
    step();

    // frame at 4, three words, cycle-by-cycle timing
    push_frame(5'd4, 6'd3);
    start = 1'b1; start_addr = 5'd4; count = 6'd3;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("t1_ren_c%0d", k), 32'(ren), 32'(k <= 3));
      check($sformatf("t1_valid_c%0d", k), 32'(out_valid), 32'(k >= 3 && k <= 5));
      check($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 5));
      check($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 6));
      step();
    end
    check("t1_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // wrap around 31 -> 0
    run_frame(5'd30, 6'd4, 1'b0, 7);
    // oversize count saturates to 32 words
    run_frame(5'd0, 6'd40, 1'b0, 35);
    // zero-length frame
    run_frame(5'd7, 6'd0, 1'b0, 1);

    // random backpressure with an ignored mid-frame start
    rand_ready = 1'b1;
    run_frame(5'd12, 6'd8, 1'b1, -1);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    step();

    // reset in the middle of a ten-word frame
    words_seen = 0;
    push_frame(5'd0, 6'd10);
    start = 1'b1; start_addr = 5'd0; count = 6'd10;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (words_seen >= 3) break;
    end
    check("mid_words_seen", 32'(words_seen >= 3), 32'd1);
    arst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    check("mid_rst_ren", 32'(ren), 32'd0);
    check("mid_rst_raddr", 32'(raddr), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_occ", 32'(dbg_occupancy), 32'd0);
    step(); step();
    arst_n = 1'b1;
    step();
    check("post_rst_state", 32'(dbg_state), 32'd0);
    run_frame(5'd0, 6'd2, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_frame_reader.md
# dm_frame_reader

Read-side sequencer for the 32×16 two-port frame RAM in the DM interface. On a START pulse it walks COUNT consecutive RAM addresses from START_ADDR, wrapping modulo 32. It drives RADDR/REN, absorbs the RAM's one-cycle read latency and presents each word on a valid/ready stream toward the DAC shifter. The host write side of the RAM is untouched; this block is the reader for that writer.

## Interface
- ADDR_WIDTH, 5, RAM address width; depth is 2^ADDR_WIDTH = 32
- DATA_WIDTH, 16, RAM word width
- CLK  in  1  single clock, rising edge
- ARST_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle request to read a frame; sampled only in IDLE
- START_ADDR  in  ADDR_WIDTH  first address of the frame, latched on START
- COUNT  in  ADDR_WIDTH+1  words to read (0..32), latched on START; values >32 saturate to 32
- RADDR  out  ADDR_WIDTH  RAM read address
- REN  out  1  RAM read enable (active high)
- RD  in  DATA_WIDTH  RAM read data, valid the cycle after REN
- OUT_DATA  out  DATA_WIDTH  stream data
- OUT_VALID  out  1  stream valid
- OUT_READY  in  1  stream ready from downstream
- OUT_LAST  out  1  high with the final word of the frame
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse at frame completion

## Operation
- States:
  - IDLE: wait for START.
  - ISSUE: reads remain to be issued.
  - DRAIN: all reads issued; words are still in flight or buffered.
- IDLE→ISSUE on START with latched COUNT≠0.
- START with COUNT=0: no reads are issued. DONE pulses the next cycle. BUSY stays low.
- ISSUE→DRAIN when the last REN is issued. DRAIN→IDLE on the handshake (OUT_VALID & OUT_READY) of the word with OUT_LAST.
- START is ignored outside IDLE. START_ADDR and COUNT are don't-care outside the START cycle.
- Address counter: starts at START_ADDR and increments by 1 per issued read. The ADDR_WIDTH-bit counter wraps 31→0.
- Remaining-count register: ADDR_WIDTH+1 bits, decremented per issued read.
- Output buffer: 2 entries, FIFO order.
- Issue rule: REN=1 in a cycle only when in ISSUE and (occupancy + in_flight − pop_this_cycle) < 2, where in_flight is 0 or 1. This guarantees a returning RD word always has a slot, and allows full throughput under OUT_READY=1.
- RD is captured into the buffer on the edge ending the cycle after REN.
- OUT_LAST is carried with each buffered word. It is set on the word from the final issued read.
- Outputs with no valid data: OUT_DATA holds its last value and OUT_LAST=0. Downstream must use OUT_VALID only.
- Once OUT_VALID is asserted, OUT_DATA and OUT_LAST stay stable until the handshake.
- The host may write the RAM concurrently. Data read from an address written in the same cycle is whatever the RAM returns; this block neither checks nor blocks collisions.

## Timing
- Reset values (asynchronous, on ARST_N low): state=IDLE, REN=0, RADDR=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, BUSY=0, DONE=0.
- Reset flushes the buffer and the in-flight flag. RAM contents are unaffected.
- Reset mid-frame: outputs reach the reset values with no further REN. After ARST_N releases, the block is in IDLE and the next START begins a fresh frame.
- Latency, with START high in cycle 0:
  - cycle 1: REN=1, RADDR=START_ADDR, BUSY=1.
  - cycle 2: RD valid.
  - cycle 3: OUT_VALID=1 with mem[START_ADDR].
- Throughput: with OUT_READY held high, one word per cycle. A frame of N words finishes its last handshake in cycle N+2.
- DONE pulses the cycle after the OUT_LAST handshake. BUSY is low in that same cycle.
- START is accepted in the DONE cycle, since the state is already IDLE.
- Backpressure: while OUT_READY=0 the buffer fills to 2 and REN stays 0. REN resumes in the cycle OUT_READY rises.

## Structure
- Shared package dm_pkg holds:
  - state enum (IDLE/ISSUE/DRAIN);
  - DM_RAM_AW=5, DM_RAM_DW=16;
  - DM_RAM_DEPTH=32.
- Sub-module dm_skid_buf: 2-entry buffer of {last, data}. Ports: push, data_in, pop, data_out, valid, occupancy.
- The top level holds the FSM, address and remaining-count counters, in-flight flag and issue logic.

## Test plan
- RAM preloaded mem[i]=0xA000+i; START_ADDR=4, COUNT=3, OUT_READY=1 → REN in cycles 1–3 with RADDR 4,5,6. Stream outputs 0xA004, 0xA005, 0xA006 in cycles 3–5, OUT_LAST on 0xA006. DONE in cycle 6.
- START_ADDR=30, COUNT=4 → RADDR sequence 30,31,0,1. Data 0xA01E, 0xA01F, 0xA000, 0xA001.
- COUNT=40 with START_ADDR=0 → exactly 32 words, 0xA000..0xA01F. OUT_LAST on 0xA01F.
- COUNT=0 → REN never asserted, OUT_VALID never asserted. DONE in cycle 1, BUSY stays 0.
- COUNT=8, OUT_READY toggled with a random 50% duty:
  - all 8 words arrive in order, none lost or duplicated;
  - OUT_DATA stays stable while OUT_VALID is high and OUT_READY is low;
  - occupancy never exceeds 2;
  - a START during the frame is ignored.
- ARST_N pulsed low after 3 words of a COUNT=10 frame → all outputs 0 immediately. After release, a new START with START_ADDR=0, COUNT=2 yields 0xA000, 0xA001 and DONE.
